// File: rtl/gamepad_reader.sv
// NES-style serial gamepad poller: drives GLatch/GPulse, samples the
// synchronised data line, and publishes the 8 buttons atomically per frame.
module gamepad_reader #(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150,
  parameter int POLL_CYCLES  = 416667
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       GamePadData,
  output logic       GLatch,
  output logic       GPulse,
  output logic [7:0] GamePad,
  output logic       Update
);

  localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PHW    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int PW     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  localparam logic [PHW-1:0] LATCH_LAST = PHW'(LATCH_CYCLES - 1);
  localparam logic [PHW-1:0] HALF_LAST  = PHW'(HALF_CYCLES - 1);
  localparam logic [PW-1:0]  POLL_LAST  = PW'(POLL_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LATCH = 2'd1;
  localparam logic [1:0] LOW   = 2'd2;
  localparam logic [1:0] HIGH  = 2'd3;

  logic [1:0]     state;
  logic [1:0]     sync;
  logic [PW-1:0]  poll;
  logic [PHW-1:0] phase;
  logic [2:0]     k;
  logic [6:0]     sr;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      sync    <= 2'b11;
      poll    <= '0;
      phase   <= '0;
      k       <= '0;
      sr      <= '0;
      GLatch  <= 1'b0;
      GPulse  <= 1'b0;
      GamePad <= 8'h00;
      Update  <= 1'b0;
    end else begin
      sync   <= {sync[0], GamePadData};
      Update <= 1'b0;
      // Poll counter free-runs; reload below on the GLatch rising edge wins
      if (poll != '0) poll <= poll - 1'b1;
      case (state)
        IDLE: begin
          if (poll == '0) begin
            state  <= LATCH;
            GLatch <= 1'b1;
            poll   <= POLL_LAST;
            phase  <= LATCH_LAST;
          end
        end
        LATCH: begin
          if (phase == '0) begin
            state  <= LOW;
            GLatch <= 1'b0;
            phase  <= HALF_LAST;
            k      <= '0;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        LOW: begin
          if (phase == '0) begin
            // Bits arrive A first; shifting right leaves bit 0 = A after 7 shifts
            if (k == 3'd7) begin
              state   <= IDLE;
              GamePad <= ~{sync[1], sr};
              Update  <= 1'b1;
            end else begin
              sr     <= {sync[1], sr[6:1]};
              state  <= HIGH;
              GPulse <= 1'b1;
              phase  <= HALF_LAST;
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end
        default: begin
          if (phase == '0) begin
            state  <= LOW;
            GPulse <= 1'b0;
            k      <= k + 1'b1;
            phase  <= HALF_LAST;
          end else begin
            phase <= phase - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamepad_reader.sv
// Bench for gamepad_reader: randomized button patterns from a pad model,
// frame timing and published byte checked against expectations from the rules.
module tb_gamepad_reader;
  localparam int LC = 4, HC = 3, PC = 64;
  localparam int FRAME = LC + 15 * HC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_pin;
  logic glatch, gpulse, upd;
  logic [7:0] gp;

  int checks = 0;
  int failures = 0;

  logic [7:0] pressed = 8'h00;
  int mode = 0;      // 0 = pad model, 1 = line stuck high, 2 = line stuck low
  int idx = 0;
  logic gpulse_d = 1'b0;

  logic       tr_l [0:255];
  logic       tr_p [0:255];
  logic       tr_u [0:255];
  logic [7:0] tr_g [0:255];

  always #5 clk = ~clk;

  gamepad_reader #(.LATCH_CYCLES(LC), .HALF_CYCLES(HC), .POLL_CYCLES(PC)) dut (
    .Clock(clk), .Reset(rst), .GamePadData(data_pin),
    .GLatch(glatch), .GPulse(gpulse), .GamePad(gp), .Update(upd)
  );

  // Pad: latch loads bit 0 (A); every GPulse rise presents the next button
  always @(negedge clk) begin
    if (glatch) idx <= 0;
    else if (gpulse && !gpulse_d) idx <= idx + 1;
    gpulse_d <= gpulse;
  end

  assign data_pin = (mode == 1) ? 1'b1 :
                    (mode == 2) ? 1'b0 :
                    (idx < 8)   ? ~pressed[idx[2:0]] : 1'b1;

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr_l[i] = glatch; tr_p[i] = gpulse; tr_u[i] = upd; tr_g[i] = gp;
    end
  endtask

  task automatic wait_update(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (upd) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (glatch !== 1'b0) begin failures++; $display("FAIL reset_glatch got=%b exp=0", glatch); end
    checks++; if (gpulse !== 1'b0) begin failures++; $display("FAIL reset_gpulse got=%b exp=0", gpulse); end
    checks++; if (upd !== 1'b0) begin failures++; $display("FAIL reset_update got=%b exp=0", upd); end
    checks++; if (gp !== 8'h00) begin failures++; $display("FAIL reset_gamepad got=%h exp=00", gp); end
  endtask

  task automatic test_reset_release;
    int rises, badw, run, nxt, nupd, overlap;
    pressed = 8'($urandom); mode = 0;
    rst = 1'b0;
    record(140);
    checks++; if (tr_l[0] !== 1'b1) begin failures++; $display("FAIL first_latch got=%b exp=1", tr_l[0]); end
    run = 0;
    while (run < 20 && tr_l[run] === 1'b1) run++;
    checks++; if (run != LC) begin failures++; $display("FAIL latch_width got=%0d exp=%0d", run, LC); end
    rises = 0; badw = 0; run = 0; overlap = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (tr_p[i]) run++;
      else begin if (run != 0 && run != HC) badw++; run = 0; end
      if (i > 0 && tr_p[i] && !tr_p[i-1]) rises++;
      if (tr_p[i] && tr_l[i]) overlap++;
    end
    checks++; if (rises != 7) begin failures++; $display("FAIL pulse_count got=%0d exp=7", rises); end
    checks++; if (badw != 0) begin failures++; $display("FAIL pulse_width bad_runs=%0d exp=0", badw); end
    checks++; if (overlap != 0) begin failures++; $display("FAIL pulse_during_latch got=%0d exp=0", overlap); end
    checks++; if (tr_u[FRAME] !== 1'b1) begin failures++; $display("FAIL update_at_frame got=%b exp=1", tr_u[FRAME]); end
    checks++; if (tr_g[FRAME-1] !== 8'h00) begin failures++; $display("FAIL gamepad_pre_update got=%h exp=00", tr_g[FRAME-1]); end
    checks++; if (tr_g[FRAME] !== pressed) begin failures++; $display("FAIL first_frame_value got=%h exp=%h", tr_g[FRAME], pressed); end
    nxt = -1;
    for (int i = 1; i < 140; i++) if (nxt < 0 && tr_l[i] && !tr_l[i-1]) nxt = i;
    checks++; if (nxt != PC) begin failures++; $display("FAIL poll_period got=%0d exp=%0d", nxt, PC); end
    nupd = 0;
    for (int i = 0; i < 140; i++) if (tr_u[i]) nupd++;
    checks++; if (nupd != 2) begin failures++; $display("FAIL update_count got=%0d exp=2", nupd); end
  endtask

  task automatic test_pattern;
    bit ok1, ok2;
    int bad;
    pressed = 8'h49; mode = 0;
    wait_update(ok1); wait_update(ok2);
    checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL pattern_timeout got=%b%b exp=11", ok1, ok2); end
    checks++; if (gp !== 8'h49) begin failures++; $display("FAIL pattern_value got=%h exp=49", gp); end
    record(PC);
    bad = 0;
    for (int i = 0; i < PC - 1; i++) if (tr_g[i] !== 8'h49 || tr_u[i] !== 1'b0) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL pattern_hold bad_cycles=%0d exp=0", bad); end
    checks++; if (tr_u[PC-1] !== 1'b1) begin failures++; $display("FAIL pattern_next_update got=%b exp=1", tr_u[PC-1]); end
  endtask

  task automatic test_unplugged;
    bit ok1, ok2;
    int bad;
    mode = 1;
    wait_update(ok1); wait_update(ok2);
    checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL unplugged_timeout got=%b%b exp=11", ok1, ok2); end
    checks++; if (gp !== 8'h00) begin failures++; $display("FAIL unplugged_value got=%h exp=00", gp); end
    record(PC);
    bad = 0;
    for (int i = 0; i < PC - 1; i++) if (tr_u[i] !== 1'b0 || tr_g[i] !== 8'h00) bad++;
    checks++; if (bad != 0 || tr_u[PC-1] !== 1'b1) begin failures++; $display("FAIL unplugged_period bad=%0d last_update=%b exp=0,1", bad, tr_u[PC-1]); end
  endtask

  task automatic test_all_pressed;
    bit ok1, ok2;
    mode = 2;
    wait_update(ok1); wait_update(ok2);
    checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL allpressed_timeout got=%b%b exp=11", ok1, ok2); end
    checks++; if (gp !== 8'hFF) begin failures++; $display("FAIL allpressed_value got=%h exp=ff", gp); end
  endtask

  task automatic test_reset_mid;
    bit ok1, ok2, seen;
    int bad, nupd;
    mode = 0; pressed = 8'hFF;
    wait_update(ok1); wait_update(ok2);
    checks++; if (gp !== 8'hFF) begin failures++; $display("FAIL mid_setup_value got=%h exp=ff", gp); end
    pressed = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); if (glatch) seen = 1'b1; end
    checks++; if (!seen) begin failures++; $display("FAIL mid_latch_timeout got=0 exp=1"); end
    // Second cycle of LOW phase k=3
    repeat (LC + 6 * HC + 1) @(negedge clk);
    checks++; if (gpulse !== 1'b0 || glatch !== 1'b0) begin failures++; $display("FAIL mid_in_low got=%b%b exp=00", glatch, gpulse); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({glatch, gpulse, upd, gp} !== 11'd0) begin failures++; $display("FAIL mid_async_clear got=%b%b%b %h exp=000 00", glatch, gpulse, upd, gp); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (upd || glatch || gp !== 8'h00) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL mid_held_in_reset bad=%0d exp=0", bad); end
    rst = 1'b0;
    record(FRAME + 1);
    checks++; if (tr_l[0] !== 1'b1) begin failures++; $display("FAIL mid_restart_latch got=%b exp=1", tr_l[0]); end
    nupd = 0;
    for (int i = 0; i < FRAME; i++) if (tr_u[i]) nupd++;
    checks++; if (nupd != 0 || tr_u[FRAME] !== 1'b1) begin failures++; $display("FAIL mid_restart_update early=%0d at_frame=%b exp=0,1", nupd, tr_u[FRAME]); end
    checks++; if (tr_g[FRAME] !== 8'h00) begin failures++; $display("FAIL mid_restart_value got=%h exp=00", tr_g[FRAME]); end
  endtask

  task automatic test_unchanged;
    bit ok1, ok2;
    int bad, nupd, badpos;
    pressed = 8'($urandom); mode = 0;
    wait_update(ok1); wait_update(ok2);
    checks++; if (gp !== pressed) begin failures++; $display("FAIL unchanged_setup got=%h exp=%h", gp, pressed); end
    record(3 * PC);
    bad = 0; nupd = 0; badpos = 0;
    for (int i = 0; i < 3 * PC; i++) begin
      if (tr_g[i] !== pressed) bad++;
      if (tr_u[i]) begin nupd++; if ((i % PC) != PC - 1) badpos++; end
    end
    checks++; if (nupd != 3 || badpos != 0) begin failures++; $display("FAIL unchanged_updates got=%0d misplaced=%0d exp=3,0", nupd, badpos); end
    checks++; if (bad != 0) begin failures++; $display("FAIL unchanged_glitch bad_cycles=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset;
    test_reset_release;
    test_pattern;
    test_unplugged;
    test_all_pressed;
    test_reset_mid;
    test_unchanged;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
